// File: rtl/ram_n_pkg.sv
// Shared constants for the ram_n memory blocks: FSM encoding and default geometry.
package ram_n_pkg;
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 3;
endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: state register and sweep counter that zero the array one word per cycle.
// Sweep lasts 2**ADDR_W cycles; i_clr is ignored while a sweep is running.
module ram_clear_seq
  import ram_n_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_adr,
  output logic              o_ready
);
  localparam logic [ADDR_W-1:0] LAST_ADR = {ADDR_W{1'b1}};

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ready;

  // Termination compares against the last address, so the counter never wraps mid-sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == LAST_ADR) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        default: begin
          if (i_clr) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_clr_we  = (r_state == ST_CLEAR);
  assign o_clr_adr = r_cnt;
  assign o_ready   = r_ready;
endmodule

// File: rtl/ram_n.sv
// Register-array RAM with zero-latency read and a sequenced whole-array clear.
// Writes land on the next edge; while clearing (ready=0) loads are dropped and out reads 0.
module ram_n
  import ram_n_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr,
  input  logic [WIDTH-1:0]  data,
  input  logic              load,
  input  logic              clr,
  output logic [WIDTH-1:0]  out,
  output logic              ready
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_adr;
  logic              w_ready;
  logic              w_user_we;

  ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (reset),
    .i_clr     (clr),
    .o_clr_we  (w_clr_we),
    .o_clr_adr (w_clr_adr),
    .o_ready   (w_ready)
  );

  // A clr request in the same cycle as a load wins; the load is dropped.
  assign w_user_we = w_ready && load && !clr;

  // No reset on storage so large arrays can map to memory; zeroing is done by the sweep.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_adr] <= '0;
    end else if (w_user_we) begin
      r_mem[adr] <= data;
    end
  end

  assign out   = w_ready ? r_mem[adr] : '0;
  assign ready = w_ready;
endmodule

// File: tb/tb_ram_n.sv
// Randomized self-checking bench for ram_n against an array-based reference model.
module tb_ram_n;
  localparam int W  = 16;
  localparam int AW = 3;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] adr;
  logic [W-1:0]  data;
  logic          load;
  logic          clr;
  logic [W-1:0]  out;
  logic          ready;

  logic          p_reset;
  logic [5:0]    p_adr;
  logic [7:0]    p_data;
  logic          p_load;
  logic          p_clr;
  logic [7:0]    p_out;
  logic          p_ready;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] model [D];

  ram_n dut (
    .clk   (clk),
    .reset (reset),
    .adr   (adr),
    .data  (data),
    .load  (load),
    .clr   (clr),
    .out   (out),
    .ready (ready)
  );

  ram_n #(.WIDTH(8), .ADDR_W(6)) dut_w8a6 (
    .clk   (clk),
    .reset (p_reset),
    .adr   (p_adr),
    .data  (p_data),
    .load  (p_load),
    .clr   (p_clr),
    .out   (p_out),
    .ready (p_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_zero;
    for (int a = 0; a < D; a++) model[a] = '0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < D; a++) begin
      adr = AW'(a);
      #1;
      chk(tag, 32'(out), 32'(model[a]));
    end
  endtask

  // Called with the DUT in its first sweep cycle; expects ready low for n edges then high.
  task automatic expect_sweep(input string tag, input int n, input bit inject);
    for (int i = 1; i <= n; i++) begin
      chk({tag, "_rdy"}, 32'(ready), 32'd0);
      chk({tag, "_out"}, 32'(out), 32'd0);
      if (inject && i == 6) begin
        adr  = 3'd3;
        data = 16'hAAAA;
        load = 1'b1;
        clr  = 1'b1;
      end
      tick;
      load = 1'b0;
      clr  = 1'b0;
    end
    chk({tag, "_done"}, 32'(ready), 32'd1);
    model_zero();
  endtask

  task automatic write_word(input int a, input logic [W-1:0] d);
    adr  = AW'(a);
    data = d;
    load = 1'b1;
    tick;
    load = 1'b0;
    model[a] = d;
  endtask

  initial begin
    int cyc;
    int a;
    logic [W-1:0] d;
    bit ld;

    reset = 1'b1; load = 1'b0; clr = 1'b0; adr = '0; data = '0;
    p_reset = 1'b1; p_load = 1'b0; p_clr = 1'b0; p_adr = '0; p_data = '0;
    model_zero();
    tick;
    tick;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_out", 32'(out), 32'd0);

    reset = 1'b0;
    expect_sweep("init", D, 1'b0);
    read_all("init_rd");

    // Write cycle still shows the old word; new value visible from the edge on.
    adr = 3'd5; data = 16'hBEEF; load = 1'b1;
    #1 chk("wr5_old", 32'(out), 32'h0);
    tick; load = 1'b0; model[5] = 16'hBEEF;
    chk("wr5_new", 32'(out), 32'hBEEF);
    adr = 3'd0; data = 16'h1234; load = 1'b1;
    #1 chk("wr0_old", 32'(out), 32'h0);
    tick; load = 1'b0; model[0] = 16'h1234;
    chk("wr0_new", 32'(out), 32'h1234);
    read_all("wr_rd");

    for (int i = 0; i < D; i++) write_word(i, 16'hFFFF);
    read_all("fill_rd");

    adr = 3'd2; data = 16'h5555; load = 1'b1; clr = 1'b1;
    tick; load = 1'b0; clr = 1'b0;
    expect_sweep("clr", D, 1'b0);
    read_all("clr_rd");

    for (int i = 0; i < D; i++) write_word(i, W'(16'h1111 * (i + 1)));
    clr = 1'b1;
    tick; clr = 1'b0;
    expect_sweep("clr_inj", D, 1'b1);
    read_all("clr_inj_rd");

    for (int k = 0; k < 60; k++) begin
      a  = $urandom_range(0, D - 1);
      d  = W'($urandom);
      ld = 1'($urandom_range(0, 1));
      adr = AW'(a); data = d; load = ld;
      #1 chk("rnd_pre", 32'(out), 32'(model[a]));
      tick; load = 1'b0;
      if (ld) model[a] = d;
      chk("rnd_post", 32'(out), 32'(model[a]));
      if (k % 20 == 19) begin
        clr = 1'b1;
        tick; clr = 1'b0;
        expect_sweep("rnd_clr", D, 1'b0);
        read_all("rnd_clr_rd");
      end
    end

    // Asynchronous reset from IDLE with a non-zero word on the read port.
    write_word(1, 16'h4321);
    adr = 3'd1;
    #3 reset = 1'b1;
    #1 chk("rst_idle_rdy", 32'(ready), 32'd0);
    chk("rst_idle_out", 32'(out), 32'd0);
    tick; reset = 1'b0;
    expect_sweep("rst_idle", D, 1'b0);
    read_all("rst_idle_rd");

    for (int i = 0; i < D; i++) write_word(i, 16'h0F0F);
    clr = 1'b1;
    tick; clr = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    #3 reset = 1'b1;
    #1 chk("rst_mid_rdy", 32'(ready), 32'd0);
    chk("rst_mid_out", 32'(out), 32'd0);
    tick; reset = 1'b0;
    expect_sweep("rst_mid", D, 1'b0);
    read_all("rst_mid_rd");

    adr = 3'd6; data = 16'hC0DE; load = 1'b1;
    #3 reset = 1'b1;
    tick; reset = 1'b0; load = 1'b0;
    expect_sweep("rst_wr", D, 1'b0);
    read_all("rst_wr_rd");

    p_reset = 1'b0;
    cyc = 0;
    while (!p_ready && cyc < 200) begin
      tick;
      cyc++;
    end
    chk("p_sweep_len", 32'(cyc), 32'd64);
    p_adr = 6'd63; p_data = 8'h7F; p_load = 1'b1;
    tick; p_load = 1'b0;
    chk("p_rd63", 32'(p_out), 32'h7F);
    p_adr = 6'd62;
    #1 chk("p_rd62", 32'(p_out), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_n.md
RAM_N -- requirements
Module: ram_n

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W words (8 at default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 adr  input  ADDR_W  word address for read and write.
REQ-006 data  input  WIDTH  write data.
REQ-007 load  input  1  write strobe; writes data to word adr at next rising clk edge when ready=1.
REQ-008 clr  input  1  single-cycle request to zero the whole array.
REQ-009 out  output  WIDTH  read data of word adr.
REQ-010 ready  output  1  high when array is usable; low during a clear sweep.

Function
REQ-011 The block SHALL have two states: CLEAR and IDLE.
REQ-012 In IDLE, out SHALL equal mem[adr] combinationally (zero read latency), as a plain array of registers addressed by adr.
REQ-013 In IDLE with load=1 and clr=0, mem[adr] SHALL take data at the rising edge; out shows new value from that edge on (no write-through in the same cycle).
REQ-014 Only the addressed word SHALL change on a write; all other words hold.
REQ-015 In IDLE, clr=1 SHALL move to CLEAR at the next edge with sweep counter = 0; if load=1 in the same cycle, the write SHALL be dropped.
REQ-016 In CLEAR, each edge SHALL write 0 to mem[counter] and increment counter (ADDR_W bits).
REQ-017 After writing word DEPTH-1 the block SHALL enter IDLE; a sweep therefore lasts exactly DEPTH cycles, ready rising on the edge that writes the last word.
REQ-018 In CLEAR, ready SHALL be 0, out SHALL be forced to 0, load SHALL be ignored, and clr SHALL be ignored (sweep not restarted).
REQ-019 Counter SHALL not wrap during a sweep; termination is by comparison with DEPTH-1, valid for any ADDR_W >= 1.
REQ-020 ready SHALL be a registered output decoded from state (no combinational path from inputs).

Reset
REQ-021 reset=1 SHALL immediately force state CLEAR, counter 0, ready 0, out 0, independent of clk.
REQ-022 On reset release, a full DEPTH-cycle clear sweep SHALL run; array contents are thus all zero when ready first rises.
REQ-023 reset asserted mid-sweep or mid-write SHALL abort it and restart the sweep from word 0 after release.
REQ-024 Storage words SHALL NOT be directly reset (allows array inference at large DEPTH); zeroing is solely by sweep.

Structure
REQ-025 State encoding (CLEAR=0, IDLE=1) and default WIDTH/ADDR_W constants SHALL live in the shared constants package/include used by the memory blocks.
REQ-026 One sub-module, ram_clear_seq, SHALL hold the state register and sweep counter and output clear-write enable, clear address and ready; ram_n holds the array, write mux and read mux.

Verification
REQ-027 Reset release, defaults: ready=0 for 8 cycles, then 1; read of all 8 addresses -> 0x0000.
REQ-028 IDLE: write 0xBEEF to adr 5, 0x1234 to adr 0 -> reads return 0xBEEF/0x1234, other 6 words 0x0000; out shows old value in the write cycle.
REQ-029 Fill all words with 0xFFFF, pulse clr together with load=1 to adr 2 data 0x5555 -> write dropped, ready low 8 cycles, out=0 during sweep, then all words 0x0000.
REQ-030 During sweep: load=1 adr 3 data 0xAAAA and second clr pulse -> ignored; sweep ends after original 8 cycles; word 3 = 0x0000.
REQ-031 Assert reset asynchronously (between edges) at sweep cycle 4 -> ready/out 0 immediately; after release sweep runs full 8 cycles from word 0.
REQ-032 Parameter run WIDTH=8, ADDR_W=6: sweep lasts 64 cycles; write 0x7F to adr 63 and read back 0x7F; adr 62 reads 0x00.
